oversample_serial_tx: RTL

- Transmit-side companion to the 4x-oversampling serial receiver. Accepts bytes on a valid/ready interface and frames each byte as UART-style bits: start bit, 8 data bits LSB first, then stop bits.
- Each bit is replicated BIT_SAMPLES times. The result is emitted as a WORD_W-sample parallel word every enabled clock, ready for a downstream OSERDES (WORD_W:1) driving the differential output.
- Sits in the clk_div domain. It is the stimulus source for the receiver loopback.

---
 rtl/oversample_serial_tx.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/oversample_serial_tx.sv
// Oversampling UART-style serial transmitter for the clk_div domain.
// Each byte is sent as start, d0..d7 (LSB first), then stop bits. Every bit is
// repeated BIT_SAMPLES times, and WORD_W samples leave per enabled clock with
// sample_word[WORD_W-1] first in time.
module oversample_serial_tx #(
    parameter int unsigned WORD_W      = 8,
    parameter int unsigned BIT_SAMPLES = 4,
    parameter int unsigned STOP_BITS   = 1
) (
    input  logic              clk,
    input  logic              aresetn,
    input  logic              tx_en,
    input  logic [7:0]        s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [WORD_W-1:0] sample_word,
    output logic              tx_busy,
    output logic [15:0]       frame_cnt
);

    localparam int unsigned FRAME_BITS = 9 + STOP_BITS;
    localparam int unsigned BIT_W      = $clog2(FRAME_BITS);
    localparam int unsigned SUB_W      = (BIT_SAMPLES > 1) ? $clog2(BIT_SAMPLES) : 1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FRAME = 1'b1
    } state_t;

    // Frame engine state
    state_t             state;
    state_t             state_nxt;
    logic [7:0]         frame_data;
    logic [7:0]         frame_data_nxt;
    logic [BIT_W-1:0]   bit_idx;
    logic [BIT_W-1:0]   bit_idx_nxt;
    logic [SUB_W-1:0]   sub_cnt;
    logic [SUB_W-1:0]   sub_cnt_nxt;

    // Holding register
    logic               hold_full;
    logic               hold_full_nxt;
    logic [7:0]         hold_data;
    logic [7:0]         hold_data_nxt;

    // Engine results for this cycle, applied only when tx_en is high
    logic [WORD_W-1:0]  eng_word;
    logic               eng_taken;
    logic               eng_done;

    // Registered output next values
    logic [WORD_W-1:0]  word_nxt;
    logic               ready_nxt;
    logic               busy_nxt;
    logic [15:0]        cnt_nxt;

    // Line level for a given frame bit position
    function automatic logic bit_value(input logic [BIT_W-1:0] b, input logic [7:0] d);
        if (b == '0) begin
            return 1'b0;
        end else if (b <= BIT_W'(8)) begin
            return d[3'(b - BIT_W'(1))];
        end else begin
            return 1'b1;
        end
    endfunction

    // State register: frame engine advances only when enabled
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state      <= ST_IDLE;
            frame_data <= '0;
            bit_idx    <= '0;
            sub_cnt    <= '0;
        end else if (tx_en) begin
            state      <= state_nxt;
            frame_data <= frame_data_nxt;
            bit_idx    <= bit_idx_nxt;
            sub_cnt    <= sub_cnt_nxt;
        end
    end

    // Next state: walk WORD_W samples, chaining into the held byte at frame end
    always_comb begin
        logic             act;
        logic [7:0]       dat;
        logic [BIT_W-1:0] bi;
        logic [SUB_W-1:0] sc;
        logic [WORD_W-1:0] w;
        logic             tk;
        logic             dn;
        act = (state == ST_FRAME);
        dat = frame_data;
        bi  = bit_idx;
        sc  = sub_cnt;
        w   = '0;
        tk  = 1'b0;
        dn  = 1'b0;
        for (int i = 0; i < WORD_W; i++) begin
            if (!act && hold_full && !tk) begin
                act = 1'b1;
                dat = hold_data;
                bi  = '0;
                sc  = '0;
                tk  = 1'b1;
            end
            if (act) begin
                w = {w[WORD_W-2:0], bit_value(bi, dat)};
                if (sc == SUB_W'(BIT_SAMPLES - 1)) begin
                    sc = '0;
                    if (bi == BIT_W'(FRAME_BITS - 1)) begin
                        bi  = '0;
                        act = 1'b0;
                        dn  = 1'b1;
                    end else begin
                        bi = bi + BIT_W'(1);
                    end
                end else begin
                    sc = sc + SUB_W'(1);
                end
            end else begin
                w = {w[WORD_W-2:0], 1'b1};
            end
        end
        state_nxt      = act ? ST_FRAME : ST_IDLE;
        frame_data_nxt = dat;
        bit_idx_nxt    = bi;
        sub_cnt_nxt    = sc;
        eng_word       = w;
        eng_taken      = tk;
        eng_done       = dn;
    end

    // Output logic: holding register, ready, busy, word and frame counter
    always_comb begin
        hold_full_nxt = hold_full;
        hold_data_nxt = hold_data;
        if (tx_en && eng_taken) begin
            hold_full_nxt = 1'b0;
        end
        if (s_valid && s_ready) begin
            hold_full_nxt = 1'b1;
            hold_data_nxt = s_data;
        end
        ready_nxt = !hold_full_nxt;
        word_nxt  = tx_en ? eng_word : sample_word;
        cnt_nxt   = (tx_en && eng_done) ? frame_cnt + 16'd1 : frame_cnt;
        busy_nxt  = hold_full_nxt || (tx_en ? (state_nxt == ST_FRAME) : (state == ST_FRAME));
    end

    // Registered outputs and holding register
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            hold_full   <= 1'b0;
            hold_data   <= '0;
            s_ready     <= 1'b1;
            sample_word <= '1;
            tx_busy     <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            hold_full   <= hold_full_nxt;
            hold_data   <= hold_data_nxt;
            s_ready     <= ready_nxt;
            sample_word <= word_nxt;
            tx_busy     <= busy_nxt;
            frame_cnt   <= cnt_nxt;
        end
    end

endmodule
